// File: rtl/branch_resolve_pkg.sv
// Shared pipeline types: comparator flags, branch kinds and the branch-resolve FSM states.
package signals;

  typedef struct packed {
    logic eq;
    logic neq;
    logic lt;
    logic gt;
  } compare_t;

  typedef enum logic [2:0] {
    NONE = 3'd0,
    EQ   = 3'd1,
    NE   = 3'd2,
    LEZ  = 3'd3,
    GTZ  = 3'd4,
    LTZ  = 3'd5,
    GEZ  = 3'd6
  } branch_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SLOT     = 2'd1,
    REDIRECT = 2'd2
  } branch_state_t;

endpackage

// File: rtl/branch_resolve_condition.sv
// Pure combinational branch condition: maps branch kind plus comparator flags to taken.
module branch_condition
  import signals::*;
(
  input  branch_t  i_type,
  input  compare_t i_cmp,
  output logic     o_taken
);

  // Condition decode; zero-compare forms rely on operand b being 0
  always_comb begin
    o_taken = 1'b0;
    case (i_type)
      EQ:      o_taken = i_cmp.eq;
      NE:      o_taken = i_cmp.neq;
      LEZ:     o_taken = i_cmp.lt | i_cmp.eq;
      GTZ:     o_taken = i_cmp.gt;
      LTZ:     o_taken = i_cmp.lt;
      GEZ:     o_taken = i_cmp.gt | i_cmp.eq;
      default: o_taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_resolve.sv
// Branch resolution stage: decides taken/not-taken, sequences the delay slot,
// and issues the fetch redirect and r31 link write.
module branch_resolve
  import signals::*;
#(
  parameter int N = 32
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  branch_t       in_type,
  input  logic          in_likely,
  input  logic          in_link,
  input  compare_t      in_cmp,
  input  logic [N-1:0]  in_pc,
  input  logic [N-1:0]  in_target,
  input  logic          slot_valid,
  output logic          slot_annul,
  output logic          redirect_valid,
  output logic [N-1:0]  redirect_pc,
  output logic          link_we,
  output logic [N-1:0]  link_data,
  output logic [31:0]   branch_count,
  output logic [31:0]   taken_count
);

  localparam logic [N-1:0] LINK_OFFSET = N'(4'd8);

  branch_state_t r_state;
  branch_state_t w_state_nxt;
  logic          w_taken;
  logic          w_accept;
  logic          r_taken;
  logic          r_likely;
  logic          r_link_we;
  logic [N-1:0]  r_target;
  logic [N-1:0]  r_link_data;
  logic [31:0]   r_branch_count;
  logic [31:0]   r_taken_count;

  branch_condition u_cond (
    .i_type  (in_type),
    .i_cmp   (in_cmp),
    .o_taken (w_taken)
  );

  // NONE is never a real branch, so it is not allowed to start a slot sequence
  assign w_accept = (r_state == IDLE) & in_valid & ~flush & (in_type != NONE);

  // Next-state and state-decoded outputs
  always_comb begin
    w_state_nxt    = r_state;
    in_ready       = 1'b0;
    slot_annul     = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = {N{1'b0}};
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (w_accept) begin
          w_state_nxt = SLOT;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      SLOT: begin
        if (flush) begin
          w_state_nxt = IDLE;
        end else if (slot_valid) begin
          slot_annul  = r_likely & ~r_taken;
          w_state_nxt = r_taken ? REDIRECT : IDLE;
        end else begin
          w_state_nxt = SLOT;
        end
      end
      REDIRECT: begin
        w_state_nxt = IDLE;
        if (!flush) begin
          redirect_valid = 1'b1;
          redirect_pc    = r_target;
        end else begin
          redirect_valid = 1'b0;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Branch latches, link pulse and counters
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_taken        <= 1'b0;
      r_likely       <= 1'b0;
      r_link_we      <= 1'b0;
      r_target       <= {N{1'b0}};
      r_link_data    <= {N{1'b0}};
      r_branch_count <= 32'd0;
      r_taken_count  <= 32'd0;
    end else begin
      r_link_we <= w_accept & in_link;
      if (w_accept) begin
        r_taken        <= w_taken;
        r_likely       <= in_likely;
        r_target       <= in_target;
        r_link_data    <= in_pc + LINK_OFFSET;
        r_branch_count <= r_branch_count + 32'd1;
        if (w_taken) begin
          r_taken_count <= r_taken_count + 32'd1;
        end
      end
    end
  end

  // A flush in the cycle after accept kills the pending r31 write
  assign link_we      = r_link_we & ~flush;
  assign link_data    = r_link_data;
  assign branch_count = r_branch_count;
  assign taken_count  = r_taken_count;

endmodule

// File: tb/tb_branch_resolve.sv
// Scenario bench for branch_resolve: redirects and link writes go through an
// expected/observed scoreboard; everything else is checked inline per scenario.
module tb_branch_resolve;
  import signals::*;

  localparam compare_t CMP_EQ = 4'b1000;
  localparam compare_t CMP_GT = 4'b0101;

  logic        clk;
  logic        reset_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  branch_t     in_type;
  logic        in_likely;
  logic        in_link;
  compare_t    in_cmp;
  logic [31:0] in_pc;
  logic [31:0] in_target;
  logic        slot_valid;
  logic        slot_annul;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        link_we;
  logic [31:0] link_data;
  logic [31:0] branch_count;
  logic [31:0] taken_count;

  int n_checks;
  int n_fail;
  logic [31:0] exp_branch;
  logic [31:0] exp_taken;
  logic [31:0] exp_redir[$];
  logic [31:0] obs_redir[$];
  logic [31:0] exp_link[$];
  logic [31:0] obs_link[$];

  branch_resolve #(.N(32)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .flush          (flush),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_type        (in_type),
    .in_likely      (in_likely),
    .in_link        (in_link),
    .in_cmp         (in_cmp),
    .in_pc          (in_pc),
    .in_target      (in_target),
    .slot_valid     (slot_valid),
    .slot_annul     (slot_annul),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .link_we        (link_we),
    .link_data      (link_data),
    .branch_count   (branch_count),
    .taken_count    (taken_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected finish before it");
    $fatal(1, "watchdog");
  end

  // One clock: record redirect/link pulses at the falling edge, return 1 after the rising edge
  task automatic step();
    @(negedge clk);
    if (reset_n) begin
      if (redirect_valid) obs_redir.push_back(redirect_pc);
      if (link_we) obs_link.push_back(link_data);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input branch_t t, input logic lk, input logic ln, input compare_t c,
                       input logic [31:0] pc, input logic [31:0] tgt);
    in_valid = 1'b1; in_type = t; in_likely = lk; in_link = ln; in_cmp = c;
    in_pc = pc; in_target = tgt;
    step();
    in_valid = 1'b0; in_type = NONE; in_likely = 1'b0; in_link = 1'b0; in_cmp = 4'b0000;
    in_pc = 32'h0; in_target = 32'h0;
  endtask

  task automatic drain_scoreboard(input string tag);
    while (exp_redir.size() > 0 || obs_redir.size() > 0) begin
      n_checks++;
      if (exp_redir.size() == 0) begin
        n_fail++;
        $display("FAIL %s_redirect: got unexpected redirect to %h, expected none", tag, obs_redir[0]);
        void'(obs_redir.pop_front());
      end else if (obs_redir.size() == 0) begin
        n_fail++;
        $display("FAIL %s_redirect: got no redirect, expected redirect to %h", tag, exp_redir[0]);
        void'(exp_redir.pop_front());
      end else begin
        if (obs_redir[0] !== exp_redir[0]) begin
          n_fail++;
          $display("FAIL %s_redirect_pc: got %h expected %h", tag, obs_redir[0], exp_redir[0]);
        end
        void'(obs_redir.pop_front());
        void'(exp_redir.pop_front());
      end
    end
    while (exp_link.size() > 0 || obs_link.size() > 0) begin
      n_checks++;
      if (exp_link.size() == 0) begin
        n_fail++;
        $display("FAIL %s_link: got unexpected link write %h, expected none", tag, obs_link[0]);
        void'(obs_link.pop_front());
      end else if (obs_link.size() == 0) begin
        n_fail++;
        $display("FAIL %s_link: got no link write, expected %h", tag, exp_link[0]);
        void'(exp_link.pop_front());
      end else begin
        if (obs_link[0] !== exp_link[0]) begin
          n_fail++;
          $display("FAIL %s_link_data: got %h expected %h", tag, obs_link[0], exp_link[0]);
        end
        void'(obs_link.pop_front());
        void'(exp_link.pop_front());
      end
    end
  endtask

  task automatic test_reset();
    slot_valid = 1'b1;
    #1;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    n_checks++; if (redirect_valid !== 1'b0) begin n_fail++; $display("FAIL reset_redirect_valid: got %b expected 0", redirect_valid); end
    n_checks++; if (redirect_pc !== 32'h0) begin n_fail++; $display("FAIL reset_redirect_pc: got %h expected 0", redirect_pc); end
    n_checks++; if (slot_annul !== 1'b0) begin n_fail++; $display("FAIL reset_slot_annul: got %b expected 0", slot_annul); end
    n_checks++; if (link_we !== 1'b0) begin n_fail++; $display("FAIL reset_link_we: got %b expected 0", link_we); end
    n_checks++; if (link_data !== 32'h0) begin n_fail++; $display("FAIL reset_link_data: got %h expected 0", link_data); end
    n_checks++; if (branch_count !== 32'h0) begin n_fail++; $display("FAIL reset_branch_count: got %h expected 0", branch_count); end
    n_checks++; if (taken_count !== 32'h0) begin n_fail++; $display("FAIL reset_taken_count: got %h expected 0", taken_count); end
    slot_valid = 1'b0;
  endtask

  task automatic test_beq_taken();
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL beq_ready_before: got %b expected 1", in_ready); end
    exp_redir.push_back(32'h2000);
    exp_branch = exp_branch + 32'd1;
    exp_taken  = exp_taken + 32'd1;
    offer(EQ, 1'b0, 1'b0, CMP_EQ, 32'h1000, 32'h2000);
    slot_valid = 1'b1;
    #1;
    n_checks++; if (slot_annul !== 1'b0) begin n_fail++; $display("FAIL beq_slot_annul: got %b expected 0", slot_annul); end
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL beq_ready_slot: got %b expected 0", in_ready); end
    n_checks++; if (branch_count !== exp_branch) begin n_fail++; $display("FAIL beq_branch_count: got %h expected %h", branch_count, exp_branch); end
    n_checks++; if (taken_count !== exp_taken) begin n_fail++; $display("FAIL beq_taken_count: got %h expected %h", taken_count, exp_taken); end
    step();
    slot_valid = 1'b0;
    n_checks++; if (redirect_valid !== 1'b1) begin n_fail++; $display("FAIL beq_redirect_at_e1: got %b expected 1", redirect_valid); end
    step();
    n_checks++; if (redirect_valid !== 1'b0) begin n_fail++; $display("FAIL beq_redirect_one_cycle: got %b expected 0", redirect_valid); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL beq_ready_after: got %b expected 1", in_ready); end
    drain_scoreboard("beq");
  endtask

  task automatic test_bnel_not_taken();
    exp_branch = exp_branch + 32'd1;
    offer(NE, 1'b1, 1'b0, CMP_EQ, 32'h1100, 32'h1200);
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bnel_wait_ready_%0d: got %b expected 0", i, in_ready); end
    end
    slot_valid = 1'b1;
    #1;
    n_checks++; if (slot_annul !== 1'b1) begin n_fail++; $display("FAIL bnel_slot_annul: got %b expected 1", slot_annul); end
    step();
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bnel_ready_after: got %b expected 1", in_ready); end
    n_checks++; if (slot_annul !== 1'b0) begin n_fail++; $display("FAIL bnel_idle_slot_ignored: got %b expected 0", slot_annul); end
    slot_valid = 1'b0;
    n_checks++; if (taken_count !== exp_taken) begin n_fail++; $display("FAIL bnel_taken_count: got %h expected %h", taken_count, exp_taken); end
    step();
    drain_scoreboard("bnel");
  endtask

  task automatic test_bltzal_link();
    exp_branch = exp_branch + 32'd1;
    exp_link.push_back(32'h408);
    offer(LTZ, 1'b0, 1'b1, CMP_GT, 32'h400, 32'h500);
    n_checks++; if (link_we !== 1'b1) begin n_fail++; $display("FAIL bltzal_link_we: got %b expected 1", link_we); end
    n_checks++; if (link_data !== 32'h408) begin n_fail++; $display("FAIL bltzal_link_data: got %h expected 408", link_data); end
    slot_valid = 1'b1;
    step();
    slot_valid = 1'b0;
    n_checks++; if (link_we !== 1'b0) begin n_fail++; $display("FAIL bltzal_link_pulse: got %b expected 0", link_we); end
    n_checks++; if (taken_count !== exp_taken) begin n_fail++; $display("FAIL bltzal_taken_count: got %h expected %h", taken_count, exp_taken); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bltzal_ready_after: got %b expected 1", in_ready); end
    n_checks++; if (link_data !== 32'h408) begin n_fail++; $display("FAIL bltzal_link_held: got %h expected 408", link_data); end
    step();
    drain_scoreboard("bltzal");
  endtask

  task automatic test_flush_slot();
    exp_branch = exp_branch + 32'd1;
    exp_taken  = exp_taken + 32'd1;
    offer(GTZ, 1'b0, 1'b0, CMP_GT, 32'h600, 32'h700);
    flush = 1'b1; slot_valid = 1'b1;
    #1;
    n_checks++; if (slot_annul !== 1'b0) begin n_fail++; $display("FAIL bgtz_flush_annul: got %b expected 0", slot_annul); end
    step();
    flush = 1'b0; slot_valid = 1'b0;
    n_checks++; if (redirect_valid !== 1'b0) begin n_fail++; $display("FAIL bgtz_flush_redirect: got %b expected 0", redirect_valid); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bgtz_flush_idle: got %b expected 1", in_ready); end
    exp_branch = exp_branch + 32'd1;
    offer(LTZ, 1'b1, 1'b1, CMP_GT, 32'h800, 32'h900);
    n_checks++; if (branch_count !== exp_branch) begin n_fail++; $display("FAIL flush_next_accept: got %h expected %h", branch_count, exp_branch); end
    flush = 1'b1; slot_valid = 1'b1;
    #1;
    n_checks++; if (slot_annul !== 1'b0) begin n_fail++; $display("FAIL bltzall_flush_annul: got %b expected 0", slot_annul); end
    n_checks++; if (link_we !== 1'b0) begin n_fail++; $display("FAIL bltzall_flush_link_we: got %b expected 0", link_we); end
    step();
    flush = 1'b0; slot_valid = 1'b0;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bltzall_flush_idle: got %b expected 1", in_ready); end
    step();
    drain_scoreboard("flush_slot");
  endtask

  task automatic test_flush_accept();
    flush = 1'b1;
    offer(EQ, 1'b0, 1'b0, CMP_EQ, 32'hC00, 32'hD00);
    flush = 1'b0;
    n_checks++; if (branch_count !== exp_branch) begin n_fail++; $display("FAIL flush_accept_branch_count: got %h expected %h", branch_count, exp_branch); end
    n_checks++; if (taken_count !== exp_taken) begin n_fail++; $display("FAIL flush_accept_taken_count: got %h expected %h", taken_count, exp_taken); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_accept_ready: got %b expected 1", in_ready); end
    offer(NONE, 1'b0, 1'b0, CMP_EQ, 32'hC00, 32'hD00);
    n_checks++; if (branch_count !== exp_branch) begin n_fail++; $display("FAIL none_branch_count: got %h expected %h", branch_count, exp_branch); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL none_ready: got %b expected 1", in_ready); end
    step();
    drain_scoreboard("flush_accept");
  endtask

  task automatic test_reset_redirect();
    offer(GEZ, 1'b0, 1'b0, CMP_EQ, 32'hA00, 32'hB00);
    slot_valid = 1'b1;
    step();
    slot_valid = 1'b0;
    n_checks++; if (redirect_valid !== 1'b1) begin n_fail++; $display("FAIL rst_pre_redirect_valid: got %b expected 1", redirect_valid); end
    n_checks++; if (redirect_pc !== 32'hB00) begin n_fail++; $display("FAIL rst_pre_redirect_pc: got %h expected b00", redirect_pc); end
    reset_n = 1'b0;
    #1;
    n_checks++; if (redirect_valid !== 1'b0) begin n_fail++; $display("FAIL rst_redirect_valid: got %b expected 0", redirect_valid); end
    n_checks++; if (redirect_pc !== 32'h0) begin n_fail++; $display("FAIL rst_redirect_pc: got %h expected 0", redirect_pc); end
    n_checks++; if (link_data !== 32'h0) begin n_fail++; $display("FAIL rst_link_data: got %h expected 0", link_data); end
    n_checks++; if (branch_count !== 32'h0) begin n_fail++; $display("FAIL rst_branch_count: got %h expected 0", branch_count); end
    n_checks++; if (taken_count !== 32'h0) begin n_fail++; $display("FAIL rst_taken_count: got %h expected 0", taken_count); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready: got %b expected 1", in_ready); end
    exp_branch = 32'd0;
    exp_taken  = 32'd0;
    step();
    reset_n = 1'b1;
    step();
    drain_scoreboard("reset_redirect");
  endtask

  task automatic test_wrap();
    force dut.r_branch_count = 32'hFFFF_FFFF;
    #1;
    release dut.r_branch_count;
    n_checks++; if (branch_count !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL wrap_preload: got %h expected ffffffff", branch_count); end
    offer(EQ, 1'b0, 1'b0, CMP_GT, 32'hE00, 32'hF00);
    n_checks++; if (branch_count !== 32'h0) begin n_fail++; $display("FAIL wrap_branch_count: got %h expected 0", branch_count); end
    n_checks++; if (taken_count !== exp_taken) begin n_fail++; $display("FAIL wrap_taken_count: got %h expected %h", taken_count, exp_taken); end
    slot_valid = 1'b1;
    step();
    slot_valid = 1'b0;
    step();
    drain_scoreboard("wrap");
  endtask

  initial begin
    n_checks = 0; n_fail = 0;
    exp_branch = 32'd0; exp_taken = 32'd0;
    reset_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_type = NONE;
    in_likely = 1'b0; in_link = 1'b0; in_cmp = 4'b0000;
    in_pc = 32'h0; in_target = 32'h0; slot_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    reset_n = 1'b1;
    step();
    test_beq_taken();
    test_bnel_not_taken();
    test_bltzal_link();
    test_flush_slot();
    test_flush_accept();
    test_reset_redirect();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/branch_resolve.md
# branch_resolve

Branch resolution stage directly downstream of the integer comparator. It consumes the comparator's `compare_t` flags for a branch instruction and decides taken/not-taken. It sequences the MIPS delay slot: the slot instruction is let through, or annulled for not-taken branch-likely. It then issues a one-cycle PC redirect to fetch and a link-register write for the `*AL` forms.

## Interface
Parameters:
- `N`, 32, PC/target width.

Ports:
- `clk` input, 1: the single clock; all state changes on its rising edge.
- `reset_n` input, 1: asynchronous, active-low reset.
- `flush` input, 1: synchronous pipeline kill from exception logic.
- `in_valid` input, 1: branch offered.
- `in_ready` output, 1: stage can accept a branch.
- `in_type` input, `signals::branch_t`: branch kind (NONE, EQ, NE, LEZ, GTZ, LTZ, GEZ).
- `in_likely` input, 1: branch-likely variant.
- `in_link` input, 1: `*AL` variant (writes r31).
- `in_cmp` input, `signals::compare_t`: comparator flags. For zero-compare forms, operand b = 0.
- `in_pc` input, N: branch PC.
- `in_target` input, N: computed target.
- `slot_valid` input, 1: delay-slot instruction presented this cycle.
- `slot_annul` output, 1: kill the presented slot instruction (combinational with `slot_valid`).
- `redirect_valid` output, 1: one-cycle fetch redirect.
- `redirect_pc` output, N: redirect address.
- `link_we` output, 1: one-cycle write of r31.
- `link_data` output, N: `in_pc + 8`, registered.
- `branch_count` output, 32: branches accepted.
- `taken_count` output, 32: branches taken.

## Operation
- Condition decode:
  - EQ: `eq`.
  - NE: `neq`.
  - LEZ: `lt|eq`.
  - GTZ: `gt`.
  - LTZ: `lt`.
  - GEZ: `gt|eq`.
  - NONE: never accepted (`in_valid` with NONE is ignored).
- FSM states: IDLE, SLOT, REDIRECT.
- IDLE:
  - `in_ready`=1.
  - Handshake `in_valid & in_ready & ~flush` latches taken, likely, link, target and pc+8, increments `branch_count`, and moves to SLOT.
  - `taken_count` increments on the same edge when the branch is taken.
- SLOT:
  - `in_ready`=0.
  - Waits any number of cycles for `slot_valid`.
  - On `slot_valid`, `slot_annul` = likely & ~taken.
  - Next state is REDIRECT if taken, otherwise IDLE.
- REDIRECT:
  - `redirect_valid`=1 and `redirect_pc` = latched target for exactly one cycle.
  - Then IDLE.
  - `in_ready`=0.
- Link: `link_we` pulses the cycle after acceptance when link=1, regardless of the taken result. `link_data` is held until the next acceptance.
- Counters: 32-bit, wrap modulo 2^32, not cleared by `flush`.
- `flush` in SLOT or REDIRECT:
  - Next state IDLE.
  - Pending redirect and annul are dropped (`slot_annul` forced 0 that cycle).
  - A `link_we` due that cycle is suppressed.
- Simultaneous `flush` and `in_valid` in IDLE: flush wins, nothing is accepted, counters are unchanged.

## Timing
- Reset (async assert, sync-safe deassert):
  - State IDLE.
  - `in_ready`=1.
  - `redirect_valid`=0, `redirect_pc`=0.
  - `slot_annul`=0.
  - `link_we`=0, `link_data`=0.
  - Both counters 0.
- Reset mid-operation abandons any in-flight branch with no redirect or link.
- Accept at edge E0. If slot arrives in the cycle after E0 (edge E1), `redirect_valid` is high in the E1–E2 cycle. Minimum accept-to-redirect latency is 2 cycles.
- Throughput:
  - Not-taken: one branch per 2 cycles.
  - Taken: one branch per 3 cycles.
- `slot_valid` while in IDLE or REDIRECT is ignored; `slot_annul`=0.
- `in_cmp` is sampled only on the accept edge; it need not be held afterwards.

## Structure
- `signals` package additions:
  - `branch_t` enum.
  - `branch_state_t` enum {IDLE, SLOT, REDIRECT}.
  - `compare_t` already lives there.
- Sub-module `branch_condition`: combinational `branch_t` + `compare_t` → taken. It is reusable by a future predictor checker.
- The FSM, latches and counters live in `branch_resolve`.

## Test plan
- BEQ taken (`eq`=1), pc=0x1000, target=0x2000; slot the next cycle:
  - `slot_annul`=0.
  - `redirect_valid` for 1 cycle with `redirect_pc`=0x2000.
  - `branch_count`=1, `taken_count`=1.
- BNEL not taken (`eq`=1, likely):
  - Slot arrives 3 cycles late and `slot_annul`=1 that cycle.
  - No redirect; `in_ready` returns high the next cycle.
- BLTZAL not taken, pc=0x400:
  - `link_we` pulses the cycle after accept with `link_data`=0x408.
  - No redirect; `taken_count` unchanged.
- BGTZ taken, then `flush` asserted in SLOT:
  - No redirect and no annul.
  - State IDLE; the next branch is accepted immediately.
- `flush` and `in_valid` in the same IDLE cycle: no accept, `branch_count` unchanged. `reset_n` pulsed low in REDIRECT: `redirect_valid` drops asynchronously and all outputs read reset values.
- Preload `branch_count` to 0xFFFFFFFF via force, accept one branch: the counter wraps to 0.
